// File: rtl/nock_unary_block_if.sv
// Memory request bus between nock_unary_block (master) and the memory mux (slave).
interface nock_unary_block_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 64
);
    // Handshake: the master raises mem_execute together with mem_func, address1 and
    // write_data and holds all of them stable until it samples mem_ready high on a clock
    // edge. The request retires on that edge. mem_ready while mem_execute is low is ignored.
    logic              mem_execute;
    logic [1:0]        mem_func;
    logic [ADDR_W-1:0] address1;
    logic [DATA_W-1:0] write_data;
    logic              mem_ready;
    logic [DATA_W-1:0] read_data1;

    modport master (
        output mem_execute, mem_func, address1, write_data,
        input  mem_ready, read_data1
    );

    modport slave (
        input  mem_execute, mem_func, address1, write_data,
        output mem_ready, read_data1
    );
endinterface

// File: rtl/nock_unary_block.sv
// Nock unary opcodes 3 (cell test) and 4 (increment) on one noun word, with its own memory requests.
// Optional NOCK_UNARY_TIMEOUT_EN: abort with error 8'h01 when mem_ready does not arrive in time.
module nock_unary_block #(
    parameter int         ADDR_W    = 28,
    parameter int         DATA_W    = 64,
    parameter int         VAL_W     = (DATA_W - 8) / 2,
    parameter logic [3:0] RET_FUNC  = 4'h1,
    parameter logic [3:0] RET_STATE = 4'h0,
    parameter logic [3:0] ERR_FUNC  = 4'hF
`ifdef NOCK_UNARY_TIMEOUT_EN
    , parameter int       TIMEOUT_CYCLES = 255
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] cell_address,
    input  logic [DATA_W-1:0] cell_data,
    output logic              busy,
    output logic              finished,
    output logic [7:0]        error,
    output logic [3:0]        return_sys_func,
    output logic [3:0]        return_state,
    output logic [2:0]        dbg_state,
    nock_unary_block_if.master mem
);
    localparam logic [1:0] FUNC_NONE    = 2'd0;
    localparam logic [1:0] GET_CONTENTS = 2'd1;
    localparam logic [1:0] SET_CONTENTS = 2'd2;
    localparam logic       ATOM = 1'b0;
    localparam logic       CELL = 1'b1;
    localparam int         HED_TAG = DATA_W - 7;
    localparam int         TEL_TAG = DATA_W - 8;
    localparam logic [VAL_W-1:0] NIL    = {VAL_W{1'b1}};
    localparam logic [VAL_W-1:0] NIL_M1 = {{(VAL_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        IDLE, READ_REQ, READ_WAIT, EVAL, WRITE_REQ, WRITE_WAIT, DONE, FAIL
    } state_t;

    state_t            state_q, state_d;
    logic              op_q, op_d, kind_q, kind_d;
    logic [ADDR_W-1:0] caddr_q, caddr_d;
    logic [VAL_W-1:0]  operand_q, operand_d, result;
    logic              busy_d, fin_d, exec_d, go_write, go_fail;
    logic [7:0]        err_d, fail_code;
    logic [3:0]        rsf_d, rstate_d;
    logic [1:0]        func_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              rd_is_wrapper;

`ifdef NOCK_UNARY_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic unused_bits;
    assign unused_bits = ^{cell_data[DATA_W-1:DATA_W-7], cell_data[2*VAL_W-1:VAL_W],
                           mem.read_data1[DATA_W-1:DATA_W-6]};

    assign dbg_state = state_q;

    // A read word with both tags ATOM and tel NIL wraps a plain atom held in hed.
    assign rd_is_wrapper = (mem.read_data1[HED_TAG] == ATOM) && (mem.read_data1[TEL_TAG] == ATOM)
                           && (mem.read_data1[VAL_W-1:0] == NIL);

    always_comb begin
        state_d   = state_q;
        busy_d    = busy;
        fin_d     = 1'b0;
        err_d     = error;
        rsf_d     = return_sys_func;
        rstate_d  = return_state;
        exec_d    = mem.mem_execute;
        func_d    = mem.mem_func;
        addr_d    = mem.address1;
        wdata_d   = mem.write_data;
        op_d      = op_q;
        caddr_d   = caddr_q;
        operand_d = operand_q;
        kind_d    = kind_q;
        result    = '0;
        go_write  = 1'b0;
        go_fail   = 1'b0;
        fail_code = 8'h00;
`ifdef NOCK_UNARY_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                op_d    = op;
                caddr_d = cell_address;
                err_d   = 8'h00;
                busy_d  = 1'b1;
                if (cell_data[TEL_TAG] == CELL) begin
                    state_d = READ_REQ;
                    exec_d  = 1'b1;
                    func_d  = GET_CONTENTS;
                    addr_d  = ADDR_W'(cell_data[VAL_W-1:0]);
`ifdef NOCK_UNARY_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    operand_d = cell_data[VAL_W-1:0];
                    kind_d    = ATOM;
                    state_d   = EVAL;
                end
            end
            READ_REQ, READ_WAIT: begin
                if (mem.mem_ready) begin
                    exec_d  = 1'b0;
                    func_d  = FUNC_NONE;
                    state_d = EVAL;
                    if (rd_is_wrapper) begin
                        operand_d = mem.read_data1[2*VAL_W-1:VAL_W];
                        kind_d    = ATOM;
                    end else begin
                        kind_d = CELL;
                    end
                end else if (state_q == READ_REQ) begin
                    state_d = READ_WAIT;
`ifdef NOCK_UNARY_TIMEOUT_EN
                end else if (cnt_q == TMO_LAST) begin
                    go_fail   = 1'b1;
                    fail_code = 8'h01;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            EVAL: begin
                if (!op_q) begin
                    result   = {{(VAL_W-1){1'b0}}, kind_q};
                    go_write = 1'b1;
                end else if (kind_q == CELL) begin
                    go_fail   = 1'b1;
                    fail_code = 8'h03;
                end else if (operand_q >= NIL_M1) begin
                    go_fail   = 1'b1;
                    fail_code = 8'h02;
                end else begin
                    result   = operand_q + 1'b1;
                    go_write = 1'b1;
                end
            end
            WRITE_REQ, WRITE_WAIT: begin
                if (mem.mem_ready) begin
                    exec_d   = 1'b0;
                    func_d   = FUNC_NONE;
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    fin_d    = 1'b1;
                    rsf_d    = RET_FUNC;
                    rstate_d = RET_STATE;
                end else if (state_q == WRITE_REQ) begin
                    state_d = WRITE_WAIT;
`ifdef NOCK_UNARY_TIMEOUT_EN
                end else if (cnt_q == TMO_LAST) begin
                    go_fail   = 1'b1;
                    fail_code = 8'h01;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            DONE, FAIL: state_d = IDLE;
            default:    state_d = IDLE;
        endcase

        // Result atom: zero control and tags, zero hed, result in tel.
        if (go_write) begin
            state_d = WRITE_REQ;
            exec_d  = 1'b1;
            func_d  = SET_CONTENTS;
            addr_d  = caddr_q;
            wdata_d = DATA_W'(result);
`ifdef NOCK_UNARY_TIMEOUT_EN
            cnt_d   = '0;
`endif
        end
        if (go_fail) begin
            state_d = FAIL;
            exec_d  = 1'b0;
            func_d  = FUNC_NONE;
            busy_d  = 1'b0;
            fin_d   = 1'b1;
            err_d   = fail_code;
            rsf_d   = ERR_FUNC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            busy            <= 1'b0;
            finished        <= 1'b0;
            error           <= 8'h00;
            return_sys_func <= RET_FUNC;
            return_state    <= RET_STATE;
            mem.mem_execute <= 1'b0;
            mem.mem_func    <= FUNC_NONE;
            mem.address1    <= '0;
            mem.write_data  <= '0;
            op_q            <= 1'b0;
            kind_q          <= ATOM;
            caddr_q         <= '0;
            operand_q       <= '0;
`ifdef NOCK_UNARY_TIMEOUT_EN
            cnt_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            busy            <= busy_d;
            finished        <= fin_d;
            error           <= err_d;
            return_sys_func <= rsf_d;
            return_state    <= rstate_d;
            mem.mem_execute <= exec_d;
            mem.mem_func    <= func_d;
            mem.address1    <= addr_d;
            mem.write_data  <= wdata_d;
            op_q            <= op_d;
            kind_q          <= kind_d;
            caddr_q         <= caddr_d;
            operand_q       <= operand_d;
`ifdef NOCK_UNARY_TIMEOUT_EN
            cnt_q           <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_nock_unary_block.sv
// Self-checking bench for nock_unary_block: memory responder, request scoreboard, completion monitor.
module tb_nock_unary_block;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 64;
    localparam int REQ_W  = 2 + ADDR_W + DATA_W;
    localparam logic [3:0]  RET_FUNC = 4'h1;
    localparam logic [3:0]  RET_STATE = 4'h0;
    localparam logic [3:0]  ERR_FUNC = 4'hF;
    localparam logic [1:0]  GET_C = 2'd1;
    localparam logic [1:0]  SET_C = 2'd2;
    localparam logic [27:0] NIL = 28'hFFF_FFFF;

    logic              clk, rst, start, op;
    logic [ADDR_W-1:0] cell_address;
    logic [DATA_W-1:0] cell_data;
    logic              busy, finished;
    logic [7:0]        error;
    logic [3:0]        return_sys_func, return_state;
    logic [2:0]        dbg_state;

    nock_unary_block_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    nock_unary_block #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RET_FUNC(RET_FUNC), .RET_STATE(RET_STATE),
        .ERR_FUNC(ERR_FUNC)
`ifdef NOCK_UNARY_TIMEOUT_EN
        , .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .cell_address(cell_address),
        .cell_data(cell_data), .busy(busy), .finished(finished), .error(error),
        .return_sys_func(return_sys_func), .return_state(return_state),
        .dbg_state(dbg_state), .mem(bus.master)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;
    int exp_lat = 0;
    int last_fin_lat = 0;
    int mem_delay = 0;
    bit first_req = 0;
    bit no_resp = 0;
    logic [DATA_W-1:0] rd_word = '0;
    logic [REQ_W-1:0]  exp_q[$];
    logic [11:0]       done_q[$];

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [5:0] ctrl, input logic ht, input logic tt,
                                       input logic [27:0] hed, input logic [27:0] tel);
        return {ctrl, ht, tt, hed, tel};
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_finished"}, finished, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_ret_func"}, return_sys_func, RET_FUNC);
        check({tag, "_ret_state"}, return_state, RET_STATE);
        check({tag, "_mem_execute"}, bus.mem_execute, 0);
        check({tag, "_mem_func"}, bus.mem_func, 0);
        check({tag, "_address1"}, bus.address1, 0);
        check({tag, "_write_data"}, bus.write_data, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    // memory responder: pops the request scoreboard on each new request
    initial begin
        logic [REQ_W-1:0] e;
        int  wait_left, held;
        bit  in_req, drop_chk;
        in_req = 0;
        drop_chk = 0;
        wait_left = 0;
        held = 0;
        bus.mem_ready = 1'b0;
        bus.read_data1 = '0;
        forever begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            if (rst) begin
                in_req = 0;
                drop_chk = 0;
            end else begin
                if (drop_chk) begin
                    check("exec_drop", bus.mem_execute, 0);
                    drop_chk = 0;
                end else if (!in_req && bus.mem_execute) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_req", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("req_func", bus.mem_func, e[REQ_W-1 -: 2]);
                        check("req_addr", bus.address1, e[DATA_W +: ADDR_W]);
                        if (e[REQ_W-1 -: 2] == SET_C) check("req_wdata", bus.write_data, e[DATA_W-1:0]);
                    end
                    if (first_req) begin
                        check("req_latency", cyc - start_cyc + 1, exp_lat);
                        first_req = 0;
                    end
                    in_req = 1;
                    wait_left = mem_delay;
                    held = 0;
                end
                if (in_req) begin
                    if (no_resp) begin
                        if (!bus.mem_execute) in_req = 0;
                    end else if (wait_left == 0) begin
                        bus.mem_ready = 1'b1;
                        bus.read_data1 = rd_word;
                        in_req = 0;
                        drop_chk = 1;
                        if (mem_delay > 0) check("exec_held", held, mem_delay);
                    end else begin
                        if (bus.mem_execute) held++;
                        wait_left--;
                    end
                end
            end
        end
    end

    // completion monitor
    initial begin
        logic [11:0] e;
        bit fin_prev;
        fin_prev = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (fin_prev) check("fin_one_cycle", finished, 0);
                if (finished) begin
                    if (done_q.size() == 0) begin
                        check("unexpected_finish", 1, 0);
                    end else begin
                        e = done_q.pop_front();
                        check("error", error, e[11:4]);
                        check("ret_func", return_sys_func, e[3:0]);
                        check("ret_state", return_state, RET_STATE);
                        check("busy_at_fin", busy, 0);
                    end
                end
            end
            fin_prev = finished && !rst;
        end
    end

    // driver: one operation, expectations pushed before the start strobe
    task automatic run_op(input logic op_i, input logic [27:0] addr_i, input logic [63:0] cdata,
                          input logic [63:0] rd, input int delay, input bit want_read,
                          input bit want_write, input logic [27:0] res, input logic [7:0] err,
                          input bit poke);
        bit seen;
        if (want_read) exp_q.push_back({GET_C, cdata[27:0], 64'h0});
        if (want_write) exp_q.push_back({SET_C, addr_i, mk(6'h0, 1'b0, 1'b0, 28'h0, res)});
        done_q.push_back({err, (err == 8'h00) ? RET_FUNC : ERR_FUNC});
        rd_word = rd;
        mem_delay = delay;
        exp_lat = want_read ? 1 : 2;
        first_req = 1;
        @(negedge clk);
        start = 1'b1;
        op = op_i;
        cell_address = addr_i;
        cell_data = cdata;
        start_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        op = 1'($urandom_range(0, 1));
        cell_address = 28'($urandom);
        cell_data = {$urandom, $urandom};
        check("busy_set", busy, 1);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (finished) begin
                seen = 1;
                last_fin_lat = cyc - start_cyc + 1;
            end else begin
                start = poke && (i == 1);
            end
        end
        check("finish_seen", seen, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_on_fin_ignored", busy, 0);
        check("idle_after_op", dbg_state, 0);
        check("req_drained", exp_q.size(), 0);
    endtask

    initial begin
        logic [27:0] t;
        bit o;
        int d;
        rst = 1'b1;
        start = 1'b0;
        op = 1'b0;
        cell_address = '0;
        cell_data = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // cell test on a direct atom, control bits set
        run_op(0, 28'h10, mk(6'h2A, 0, 0, 28'h3, 28'd5), '0, 0, 0, 1, 28'd0, 8'h00, 0);
        // cell test on a read true cell
        run_op(0, 28'h11, mk(6'h0, 0, 1, 28'h0, 28'h20), mk(6'h0, 1, 0, 28'h5, 28'h30), 0, 1, 1, 28'd1, 8'h00, 0);
        // increment through an atom wrapper
        run_op(1, 28'h12, mk(6'h0, 0, 1, 28'h0, 28'h40), mk(6'h0, 0, 0, 28'd41, NIL), 1, 1, 1, 28'd42, 8'h00, 0);
        // overflow boundaries
        run_op(1, 28'h13, mk(6'h0, 0, 0, 28'h0, NIL - 28'd1), '0, 0, 0, 0, 28'd0, 8'h02, 0);
        run_op(1, 28'h14, mk(6'h0, 0, 0, 28'h0, NIL), '0, 0, 0, 0, 28'd0, 8'h02, 0);
        run_op(1, 28'h15, mk(6'h0, 0, 0, 28'h0, NIL - 28'd2), '0, 0, 0, 1, NIL - 28'd1, 8'h00, 0);
        // wrapper reads as atom; atom-tagged word with non-NIL tel is a cell
        run_op(0, 28'h16, mk(6'h0, 0, 1, 28'h0, 28'h50), mk(6'h0, 0, 0, 28'd7, NIL), 2, 1, 1, 28'd0, 8'h00, 0);
        run_op(0, 28'h17, mk(6'h0, 0, 1, 28'h0, 28'h51), mk(6'h0, 0, 0, 28'd7, 28'h30), 0, 1, 1, 28'd1, 8'h00, 0);
        // crash on increment of a cell, then error clears on next start
        run_op(1, 28'h18, mk(6'h0, 0, 1, 28'h0, 28'h52), mk(6'h0, 1, 1, 28'd3, 28'd4), 0, 1, 0, 28'd0, 8'h03, 0);
        run_op(1, 28'h19, mk(6'h0, 0, 1, 28'h0, 28'h53), mk(6'h0, 0, 1, 28'd3, 28'd4), 3, 1, 0, 28'd0, 8'h03, 0);
        run_op(1, 28'h1A, mk(6'h0, 0, 0, 28'h0, 28'h1234), '0, 0, 0, 1, 28'h1235, 8'h00, 0);
        // slow memory with a start pulsed while busy
        run_op(1, 28'h1B, mk(6'h0, 0, 0, 28'h0, 28'd7), '0, 7, 0, 1, 28'd8, 8'h00, 1);
        run_op(0, 28'h1C, mk(6'h0, 0, 1, 28'h0, 28'h60), mk(6'h0, 1, 1, 28'd1, 28'd2), 7, 1, 1, 28'd1, 8'h00, 1);

        for (int k = 0; k < 8; k++) begin
            t = 28'($urandom_range(0, 32'h0FFF_FFFF));
            if (t >= NIL - 28'd1) t = 28'h0ABC;
            o = 1'($urandom_range(0, 1));
            d = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1)
                run_op(o, 28'h100 + 28'(k), mk(6'($urandom_range(0, 63)), 0, 0, 28'($urandom), t), '0, d,
                       0, 1, o ? t + 28'd1 : 28'd0, 8'h00, 0);
            else
                run_op(o, 28'h200 + 28'(k), mk(6'h0, 0, 1, 28'h0, 28'h300 + 28'(k)), mk(6'h0, 0, 0, t, NIL), d,
                       1, 1, o ? t + 28'd1 : 28'd0, 8'h00, 0);
        end

        // reset while the write is outstanding
        no_resp = 1;
        exp_q.push_back({SET_C, 28'h55, mk(6'h0, 0, 0, 28'h0, 28'd0)});
        first_req = 1;
        exp_lat = 2;
        @(negedge clk);
        start = 1'b1;
        op = 1'b0;
        cell_address = 28'h55;
        cell_data = mk(6'h0, 0, 0, 28'h0, 28'd9);
        start_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10 && !bus.mem_execute; i++) @(negedge clk);
        @(negedge clk);
        check("in_write_wait", dbg_state, 5);
        #2 rst = 1'b1;
        #1 check_reset_vals("mid_op_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        no_resp = 0;
        check("reset_req_drained", exp_q.size(), 0);
        repeat (4) begin
            @(negedge clk);
            check("no_req_after_reset", bus.mem_execute, 0);
        end

        // memory never answers
        no_resp = 1;
`ifdef NOCK_UNARY_TIMEOUT_EN
        run_op(0, 28'h66, mk(6'h0, 0, 1, 28'h0, 28'h70), '0, 0, 1, 0, 28'd0, 8'h01, 0);
        check("timeout_latency", last_fin_lat, 6);
        no_resp = 0;
`else
        exp_q.push_back({GET_C, 28'h70, 64'h0});
        first_req = 1;
        exp_lat = 1;
        @(negedge clk);
        start = 1'b1;
        op = 1'b0;
        cell_address = 28'h66;
        cell_data = mk(6'h0, 0, 1, 28'h0, 28'h70);
        start_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("hang_busy", busy, 1);
        check("hang_exec", bus.mem_execute, 1);
        check("hang_state", dbg_state, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        no_resp = 0;
        check("hang_req_drained", exp_q.size(), 0);
`endif
        run_op(1, 28'h77, mk(6'h0, 0, 0, 28'h0, 28'd99), '0, 0, 0, 1, 28'd100, 8'h00, 0);
        check("done_drained", done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/nock_unary_block.md
Name: nock_unary_block

Overview:
- Parametrised successor to the single-purpose cell-test unit; executes Nock unary opcodes 3 (cell test) and 4 (increment) on one noun word.
- Sits behind the memory mux. The traversal engine strobes it, and it issues its own read and write memory requests.
- Writes the result atom back to the operand's address and hands control back to the traversal engine with a return function/state.
- Adds three things the previous unit lacked: mode select, crash/overflow error reporting, and a busy/strobe handshake.

Parameters:
- ADDR_W, 28: memory address width.
- DATA_W, 64: memory word width.
- VAL_W, (DATA_W-8)/2: width of the hed and tel value fields.
- RET_FUNC, 4'h1: return sys func on success (read).
- RET_STATE, 4'h0: return state on success (read init).
- ERR_FUNC, 4'hF: return sys func on error.
- TIMEOUT_CYCLES, 255: maximum wait for mem_ready (feature only).

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous reset, active-high.
- start, in, 1: one-cycle request strobe.
- op, in, 1: 0 = cell test (Nock 3), 1 = increment (Nock 4).
- cell_address, in, ADDR_W: result write address.
- cell_data, in, DATA_W: operand word.
- busy, out, 1: high from the cycle after an accepted start until finished.
- finished, out, 1: one-cycle done pulse.
- error, out, 8: status code, held until the next accepted start.
- return_sys_func, out, 4: function for the traversal engine to resume with.
- return_state, out, 4: state for the traversal engine to resume with.
- mem_execute, out, 1: memory request valid.
- mem_func, out, 2: GET_CONTENTS or SET_CONTENTS, per the shared memory header.
- address1, out, ADDR_W: request address.
- write_data, out, DATA_W: write word.
- mem_ready, in, 1: request complete.
- read_data1, in, DATA_W: read result.

Behaviour:
- Word layout:
  - [DATA_W-1:DATA_W-6] control.
  - [DATA_W-7] hed_tag, [DATA_W-8] tel_tag; ATOM=0, CELL=1.
  - [2*VAL_W-1:VAL_W] hed value; [VAL_W-1:0] tel value.
  - NIL = all-ones VAL_W.
- Reset values: busy, finished, mem_execute, mem_func, address1, write_data, error = 0; return_sys_func = RET_FUNC; return_state = RET_STATE; state = IDLE. Reset mid-operation aborts immediately and issues no further requests.
- States: IDLE, READ_REQ, READ_WAIT, EVAL, WRITE_REQ, WRITE_WAIT, DONE, FAIL.
- IDLE:
  - On start, latch op, cell_address and cell_data, clear error, set busy.
  - Operand tel_tag ATOM: operand = tel value; go to EVAL.
  - Operand tel_tag CELL: go to READ_REQ with address1 = tel value.
- Memory handshake:
  - mem_execute and mem_func are driven in the *_REQ state and held through *_WAIT until mem_ready is sampled high.
  - mem_execute and mem_func drop in the cycle after mem_ready.
  - mem_ready while mem_execute is low is ignored.
- READ_WAIT, on mem_ready:
  - If the read word has hed_tag ATOM, tel_tag ATOM and tel == NIL, it is an atom wrapper: operand = its hed value, kind = ATOM.
  - Otherwise kind = CELL.
  - Go to EVAL.
- EVAL, op 0: result = 1 if kind CELL, else 0.
- EVAL, op 1:
  - kind CELL: error = 8'h03 (crash), go to FAIL.
  - operand >= NIL-1: error = 8'h02 (overflow), go to FAIL; NIL-1 would produce NIL and is rejected.
  - Otherwise result = operand + 1, computed at VAL_W width.
- WRITE_REQ: address1 = latched cell_address; write_data = {6'b0, ATOM, ATOM, VAL_W'b0, result}; mem_func = SET_CONTENTS.
- DONE:
  - finished = 1 for one cycle; busy = 0.
  - return_sys_func = RET_FUNC, return_state = RET_STATE.
  - Back to IDLE.
- FAIL:
  - Issues no write.
  - finished = 1 for one cycle; busy = 0.
  - return_sys_func = ERR_FUNC; error holds its code.
  - Back to IDLE.
- start while busy is ignored, with no state change and no error.
- start in the same cycle as finished is ignored; a new start is accepted from the following cycle.
- Latency: atom operand, write request in cycle 2 after the start edge; cell operand, read request in cycle 1.

Optional Feature:
- Macro NOCK_UNARY_TIMEOUT_EN.
- When defined: a counter runs in READ_WAIT and WRITE_WAIT. If mem_ready does not arrive within TIMEOUT_CYCLES cycles:
  - mem_execute is dropped.
  - error = 8'h01.
  - The block goes to FAIL.
  - The counter clears on each new request.
- When undefined: the block waits indefinitely, no counter logic is present, and code 8'h01 is never produced.

Test Plan:
1. op=0, cell_data tel_tag ATOM, tel=5, cell_address=0x10 -> no read; write to 0x10 with tel=0, tags ATOM/ATOM; finished 1 cycle; error 0; return_sys_func=RET_FUNC.
2. op=0, tel_tag CELL tel=0x20, read_data1 = hed CELL / tel 0x30 -> read 0x20, then write tel=1.
3. op=1, tel_tag CELL, read_data1 = atom wrapper with hed=41 -> write tel=42. Also op=1 with tel_tag ATOM, tel=NIL-1 -> no write, error 8'h02, return_sys_func=ERR_FUNC.
4. op=1, read word is a true cell -> error 8'h03, no SET_CONTENTS issued. Then a second start with an atom operand clears error to 0.
5. mem_ready delayed 7 cycles -> mem_execute held 7 cycles, then drops the cycle after ready. A start pulsed while busy is ignored. rst asserted during WRITE_WAIT -> all outputs at reset values immediately.
6. Feature on, TIMEOUT_CYCLES=4, mem_ready never asserted -> error 8'h01 after 4 wait cycles, finished pulses. Feature off -> busy stays high.
